// File: rtl/video_timing_gen_if.sv
// Raster timing and pixel bundle carried from video_timing_gen to the TMDS encoders.
interface video_timing_gen_if;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_sof;
  logic        o_eol;
  logic [7:0]  o_red;
  logic [7:0]  o_green;
  logic [7:0]  o_blue;

  modport master (
    output o_hs, o_vs, o_de, o_x, o_y, o_sof, o_eol, o_red, o_green, o_blue
  );

  modport slave (
    input o_hs, o_vs, o_de, o_x, o_y, o_sof, o_eol, o_red, o_green, o_blue
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parameterised raster timing generator with an 8-bar colour test pattern.
// All outputs are registered from the next (h,v) so sync, enable and pixels stay aligned.
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  localparam logic [11:0] H_A_END  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_FP_END = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SY_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_A_END  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] V_FP_END = 12'(V_ACTIVE + V_FP - 1);
  localparam logic [11:0] V_SY_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_ACT_N  = 12'(V_ACTIVE);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

  phase_t      h_ph, v_ph, h_ph_n, v_ph_n;
  logic [11:0] h, v, h_n, v_n;
  logic        h_wrap;
  logic        de_n, hs_n, vs_n, sof_n, eol_n;
  logic [11:0] x_n, y_n;
  logic [2:0]  bar;
  logic [23:0] rgb_n;

  always_comb begin
    h_wrap = (h == H_LAST);
    h_n    = h_wrap ? '0 : h + 12'd1;
    v_n    = v;
    if (h_wrap) v_n = (v == V_LAST) ? '0 : v + 12'd1;

    // Phase transitions key off the current count so the next phase lines up with h_n/v_n.
    h_ph_n = h_ph;
    case (h_ph)
      PH_ACTIVE: if (h == H_A_END)  h_ph_n = PH_FP;
      PH_FP:     if (h == H_FP_END) h_ph_n = PH_SYNC;
      PH_SYNC:   if (h == H_SY_END) h_ph_n = PH_BP;
      default:   if (h_wrap)        h_ph_n = PH_ACTIVE;
    endcase

    v_ph_n = v_ph;
    if (h_wrap) begin
      case (v_ph)
        PH_ACTIVE: if (v == V_A_END)  v_ph_n = PH_FP;
        PH_FP:     if (v == V_FP_END) v_ph_n = PH_SYNC;
        PH_SYNC:   if (v == V_SY_END) v_ph_n = PH_BP;
        default:   if (v == V_LAST)   v_ph_n = PH_ACTIVE;
      endcase
    end

    de_n  = (h_ph_n == PH_ACTIVE) && (v_ph_n == PH_ACTIVE);
    hs_n  = (h_ph_n == PH_SYNC) ? HS_POL : ~HS_POL;
    vs_n  = (v_ph_n == PH_SYNC) ? VS_POL : ~VS_POL;
    x_n   = de_n ? h_n : '0;
    y_n   = de_n ? v_n : '0;
    sof_n = (h_n == '0) && (v_n == '0);
    eol_n = (h_n == H_A_END) && (v_n < V_ACT_N);

    // Bar index by threshold compare: equivalent to x_n / BAR_W without a divider.
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (x_n >= 12'(k * BAR_W)) bar = 3'(k);
    end

    case (bar)
      3'd0:    rgb_n = 24'hFFFFFF;
      3'd1:    rgb_n = 24'hFFFF00;
      3'd2:    rgb_n = 24'h00FFFF;
      3'd3:    rgb_n = 24'h00FF00;
      3'd4:    rgb_n = 24'hFF00FF;
      3'd5:    rgb_n = 24'hFF0000;
      3'd6:    rgb_n = 24'h0000FF;
      default: rgb_n = 24'h000000;
    endcase
    if (!de_n) rgb_n = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h           <= H_LAST;
      v           <= V_LAST;
      h_ph        <= PH_BP;
      v_ph        <= PH_BP;
      vid.o_hs    <= ~HS_POL;
      vid.o_vs    <= ~VS_POL;
      vid.o_de    <= 1'b0;
      vid.o_x     <= '0;
      vid.o_y     <= '0;
      vid.o_sof   <= 1'b0;
      vid.o_eol   <= 1'b0;
      vid.o_red   <= '0;
      vid.o_green <= '0;
      vid.o_blue  <= '0;
    end else if (i_en) begin
      h           <= h_n;
      v           <= v_n;
      h_ph        <= h_ph_n;
      v_ph        <= v_ph_n;
      vid.o_hs    <= hs_n;
      vid.o_vs    <= vs_n;
      vid.o_de    <= de_n;
      vid.o_x     <= x_n;
      vid.o_y     <= y_n;
      vid.o_sof   <= sof_n;
      vid.o_eol   <= eol_n;
      vid.o_red   <= rgb_n[23:16];
      vid.o_green <= rgb_n[15:8];
      vid.o_blue  <= rgb_n[7:0];
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced raster, against an arithmetic (h,v) model.
module tb_video_timing_gen;

  localparam int   HA  = 32;
  localparam int   HFP = 4;
  localparam int   HSY = 6;
  localparam int   HBP = 5;
  localparam int   VA  = 6;
  localparam int   VFP = 2;
  localparam int   VSY = 2;
  localparam int   VBP = 3;
  localparam logic HSP = 1'b0;
  localparam logic VSP = 1'b1;
  localparam int   HT    = HA + HFP + HSY + HBP;
  localparam int   VT    = VA + VFP + VSY + VBP;
  localparam int   FRAME = HT * VT;
  localparam int   BW    = HA / 8;

  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk;
  logic rst_n;
  logic en;

  video_timing_gen_if vid ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_en   (en),
    .vid    (vid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int mh, mv;

  // Reference raster position: a plain counter pair advanced on enabled edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh = HT - 1;
      mv = VT - 1;
    end else if (en) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  end

  function automatic logic [52:0] exp_vec(input int h, input int v);
    logic        de, hs, vs, sof, eol;
    logic [11:0] x, y;
    logic [23:0] rgb;
    de  = (h < HA) && (v < VA);
    hs  = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : ~HSP;
    vs  = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : ~VSP;
    x   = de ? 12'(h) : 12'd0;
    y   = de ? 12'(v) : 12'd0;
    sof = (h == 0) && (v == 0);
    eol = (h == HA - 1) && (v < VA);
    rgb = de ? BAR_RGB[int'(x) / BW] : 24'h0;
    return {hs, vs, de, x, y, sof, eol, rgb};
  endfunction

  function automatic logic [52:0] obs();
    return {vid.o_hs, vid.o_vs, vid.o_de, vid.o_x, vid.o_y, vid.o_sof, vid.o_eol,
            vid.o_red, vid.o_green, vid.o_blue};
  endfunction

  function automatic logic [23:0] rgb();
    return {vid.o_red, vid.o_green, vid.o_blue};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel clock with the given enable, then compare every output against the model.
  task automatic tick(input logic e);
    en = e;
    @(negedge clk);
    chk("outputs", 64'(obs()), 64'(exp_vec(mh, mv)));
  endtask

  task automatic run_to_sof(output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      tick(1'b1);
      cyc++;
      if (vid.o_sof) ok = 1'b1;
    end
    chk("sof_found", 64'(ok), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [52:0] rv, snap;
    int frame_len, de0, hs_cnt, hs_first, vs_cnt, vs_first, vs_last, de_blank;
    int eol_cnt, eol_bad, cyc;
    bit ok;

    rst_n = 1'b0;
    en    = 1'b0;
    rv    = {~HSP, ~VSP, 51'd0};
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(obs()), 64'(rv));
    tick(1'b1);
    chk("reset_held_clk", 64'(obs()), 64'(rv));

    // First enabled edge after release lands on (0,0).
    rst_n = 1'b1;
    tick(1'b1);
    chk("first_sof", 64'(vid.o_sof), 64'd1);
    chk("first_de", 64'(vid.o_de), 64'd1);
    chk("first_xy", 64'({vid.o_x, vid.o_y}), 64'd0);
    chk("first_rgb", 64'(rgb()), 64'hFFFFFF);

    frame_len = 0; de0 = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1;
    vs_last = -1; de_blank = 0; eol_cnt = 0; eol_bad = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (c > 0) begin
        tick(1'b1);
        if (vid.o_sof) begin
          frame_len = c;
          break;
        end
      end
      if (c < HT && vid.o_de) de0++;
      if (c < HT && vid.o_hs == HSP) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
      end
      if (vid.o_vs == VSP) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
        vs_last = c;
      end
      if (c >= VA * HT && vid.o_de) de_blank++;
      if (vid.o_eol) begin
        eol_cnt++;
        if (int'(vid.o_x) != HA - 1) eol_bad++;
      end
      if (c == BW - 1) chk("bar0_last", 64'(rgb()), 64'hFFFFFF);
      if (c == BW)     chk("bar1_first", 64'(rgb()), 64'hFFFF00);
      if (c == 7 * BW) chk("bar7_first", 64'(rgb()), 64'h000000);
      if (c == HA)     chk("blank_rgb", 64'(rgb()), 64'h0);
    end
    chk("frame_len", 64'(frame_len), 64'(FRAME));
    chk("de_per_line", 64'(de0), 64'(HA));
    chk("hs_width", 64'(hs_cnt), 64'(HSY));
    chk("hs_start", 64'(hs_first), 64'(HA + HFP));
    chk("vs_width", 64'(vs_cnt), 64'(VSY * HT));
    chk("vs_start", 64'(vs_first), 64'((VA + VFP) * HT));
    chk("vs_contig", 64'(vs_last - vs_first + 1), 64'(vs_cnt));
    chk("de_vblank", 64'(de_blank), 64'd0);
    chk("eol_count", 64'(eol_cnt), 64'(VA));
    chk("eol_at_last_x", 64'(eol_bad), 64'd0);

    // Enable hold mid-line: everything freezes and the frame stretches by the held cycles.
    for (int i = 0; i < 10; i++) tick(1'b1);
    chk("hold_at_x", 64'(vid.o_x), 64'd10);
    snap = obs();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      chk("hold_freeze", 64'(obs()), 64'(snap));
    end
    run_to_sof(cyc);
    chk("frame_len_hold", 64'(cyc + 15), 64'(FRAME + 5));

    // Enable hold on the start-of-frame pulse.
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      chk("sof_held", 64'(vid.o_sof), 64'd1);
    end
    tick(1'b1);
    chk("sof_one_enabled", 64'(vid.o_sof), 64'd0);

    // Randomised enable pattern against the model.
    for (int i = 0; i < 3000; i++) tick(logic'($urandom_range(0, 3) != 0));

    // Asynchronous reset between edges, mid-line.
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      tick(1'b1);
      if (vid.o_de && vid.o_x == 12'd20) ok = 1'b1;
    end
    chk("reach_x20", 64'(ok), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 64'(obs()), 64'(rv));
    tick(1'b1);
    chk("async_reset_hold", 64'(obs()), 64'(rv));
    rst_n = 1'b1;
    tick(1'b1);
    chk("sof_after_reset", 64'(vid.o_sof), 64'd1);
    chk("rgb_after_reset", 64'(rgb()), 64'hFFFFFF);
    for (int i = 0; i < 100; i++) tick(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
